// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared definitions for the memory bus arbiter: FSM state encoding,
// requester (owner) identifiers and memory read/write direction constants.
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_ACCESS   = 2'd2,
        ST_COMPLETE = 2'd3
    } state_e;

    typedef enum logic {
        OWNER_FETCH = 1'b0,
        OWNER_LS    = 1'b1
    } owner_e;

    localparam logic RW_RD = 1'b1;
    localparam logic RW_WR = 1'b0;

endpackage

// File: rtl/mem_arb_pick.sv
// -----------------------------------------------------------------------------
// mem_arb_pick
// Combinational winner selection between the fetch and Load_Store requesters.
//   fetch_req, ls_req : request lines
//   last_owner        : owner of the most recently completed access
//   rr_mode           : 0 = Load_Store has fixed priority, 1 = round-robin
//   valid             : at least one request is present
//   winner            : selected requester (meaningful only when valid)
// -----------------------------------------------------------------------------
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic   fetch_req,
    input  logic   ls_req,
    input  owner_e last_owner,
    input  logic   rr_mode,
    output logic   valid,
    output owner_e winner
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path leaves
        // it unassigned; an unassigned path in always_comb infers a latch.
        valid  = fetch_req | ls_req;
        winner = OWNER_FETCH;
        if (fetch_req && ls_req) begin
            // Round-robin hands the bus to whoever did not own it last.
            if (rr_mode && (last_owner == OWNER_LS)) begin
                winner = OWNER_FETCH;
            end else begin
                winner = OWNER_LS;
            end
        end else if (ls_req) begin
            winner = OWNER_LS;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one memory port between the instruction-fetch and Load_Store
// requesters. The winner's address, write data and direction are latched on
// the win; the access then runs GRANT -> ACCESS (mem_en high until MFC) ->
// COMPLETE (one-cycle done pulse). A watchdog ends an ACCESS that never sees
// MFC after TIMEOUT_CYCLES cycles and raises timeout_err together with done.
//   clk, reset          : clock, synchronous active-low reset
//   fetch_*             : fetch request/address, grant and done
//   ls_*                : Load_Store request/rw/address/wdata, grant and done
//   mem_en/rw/addr/wdata: memory Enable, RW (1 = read), MAR, MDR
//   MFC                 : memory function complete
//   busy, timeout_err   : not idle; watchdog abort pulse
// -----------------------------------------------------------------------------
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 15,
    parameter int CNT_W          = 4,
    parameter int RR_MODE        = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_done,
    input  logic              ls_req,
    input  logic              ls_rw,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_done,
    output logic              mem_en,
    output logic              mem_rw,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              MFC,
    output logic              busy,
    output logic              timeout_err
);

    // Counter value seen on the last ACCESS cycle the watchdog allows.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    owner_e            last_owner_q, last_owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              pick_valid;
    owner_e            pick_winner;

    mem_arb_pick u_pick (
        .fetch_req  (fetch_req),
        .ls_req     (ls_req),
        .last_owner (last_owner_q),
        .rr_mode    (RR_MODE != 0),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    owner_d = pick_winner;
                    state_d = ST_GRANT;
                    if (pick_winner == OWNER_LS) begin
                        addr_d  = ls_addr;
                        rw_d    = ls_rw;
                        wdata_d = ls_wdata;
                    end else begin
                        // Fetch is always a read; write data is left as is.
                        addr_d = fetch_addr;
                        rw_d   = RW_RD;
                    end
                end
            end
            ST_GRANT: begin
                cnt_d   = '0;
                err_d   = 1'b0;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + CNT_W'(1);
                // MFC takes precedence over a watchdog expiring in the same cycle.
                if (MFC) begin
                    state_d = ST_COMPLETE;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_COMPLETE;
                    err_d   = 1'b1;
                end
            end
            ST_COMPLETE: begin
                last_owner_d = owner_q;
                err_d        = 1'b0;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_FETCH;
            last_owner_q <= OWNER_FETCH;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            rw_q         <= RW_RD;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    // Moore outputs decoded from the state registers only.
    assign busy        = (state_q != ST_IDLE);
    assign fetch_gnt   = busy && (owner_q == OWNER_FETCH);
    assign ls_gnt      = busy && (owner_q == OWNER_LS);
    assign fetch_done  = (state_q == ST_COMPLETE) && (owner_q == OWNER_FETCH);
    assign ls_done     = (state_q == ST_COMPLETE) && (owner_q == OWNER_LS);
    assign timeout_err = (state_q == ST_COMPLETE) && err_q;
    assign mem_en      = (state_q == ST_ACCESS);
    // RW idles at read so a stray Enable can never look like a write.
    assign mem_rw      = (state_q == ST_ACCESS) ? rw_q : RW_RD;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Two arbiters (index 0: fixed priority, index 1: round-robin) share one set
// of stimulus. Expected accesses are queued per instance when requests are
// driven; a negedge monitor checks bus values during each access and pops and
// compares the entry when the done pulse appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
    import mem_arb_pkg::*;

    localparam int AW  = 16;
    localparam int DW  = 16;
    localparam int TMO = 15;
    localparam int CW  = 4;

    logic          clk        = 1'b0;
    logic          reset      = 1'b0;
    logic          fetch_req  = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic          ls_req     = 1'b0;
    logic          ls_rw      = 1'b1;
    logic [AW-1:0] ls_addr    = '0;
    logic [DW-1:0] ls_wdata   = '0;
    logic          MFC        = 1'b0;

    logic [1:0]    fetch_gnt, fetch_done, ls_gnt, ls_done;
    logic [1:0]    mem_en, mem_rw, busy, timeout_err;
    logic [AW-1:0] mem_addr [2];
    logic [DW-1:0] mem_wdata [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter #(
            .ADDR_W         (AW),
            .DATA_W         (DW),
            .TIMEOUT_CYCLES (TMO),
            .CNT_W          (CW),
            .RR_MODE        (g)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .fetch_req   (fetch_req),
            .fetch_addr  (fetch_addr),
            .fetch_gnt   (fetch_gnt[g]),
            .fetch_done  (fetch_done[g]),
            .ls_req      (ls_req),
            .ls_rw       (ls_rw),
            .ls_addr     (ls_addr),
            .ls_wdata    (ls_wdata),
            .ls_gnt      (ls_gnt[g]),
            .ls_done     (ls_done[g]),
            .mem_en      (mem_en[g]),
            .mem_rw      (mem_rw[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .MFC         (MFC),
            .busy        (busy[g]),
            .timeout_err (timeout_err[g])
        );
    end

    typedef struct {
        owner_e        owner;
        logic [AW-1:0] addr;
        logic          rw;
        logic [DW-1:0] wdata;
        logic          chk_wdata;
        logic          tmo;
        int            en_cycles;
    } exp_t;

    exp_t sb0[$];
    exp_t sb1[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   en_cnt  [2];
    int   gnt_cnt [2];
    logic bad     [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input owner_e o, input logic [AW-1:0] a, input logic rw,
                                input logic [DW-1:0] wd, input logic tmo, input int en);
        exp_t e;
        e.owner     = o;
        e.addr      = a;
        e.rw        = (o == OWNER_LS) ? rw : RW_RD;
        e.wdata     = wd;
        e.chk_wdata = (o == OWNER_LS);
        e.tmo       = tmo;
        e.en_cycles = en;
        return e;
    endfunction

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (!reset) begin
            sb0.delete();
            sb1.delete();
            for (int d = 0; d < 2; d++) begin
                en_cnt[d]  = 0;
                gnt_cnt[d] = 0;
                bad[d]     = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                exp_t  e;
                bit    have;
                logic  own_gnt, oth_gnt;
                string sfx;
                sfx  = $sformatf("[%0d]", d);
                have = (d == 0) ? (sb0.size() != 0) : (sb1.size() != 0);
                if (have) e = (d == 0) ? sb0[0] : sb1[0];

                if (fetch_gnt[d] || ls_gnt[d]) begin
                    check({"one_gnt", sfx}, fetch_gnt[d] & ls_gnt[d], 1'b0);
                    if (!have) begin
                        check({"gnt_unexpected", sfx}, 1'b1, 1'b0);
                    end else begin
                        own_gnt = (e.owner == OWNER_LS) ? ls_gnt[d] : fetch_gnt[d];
                        oth_gnt = (e.owner == OWNER_LS) ? fetch_gnt[d] : ls_gnt[d];
                        if (own_gnt && !oth_gnt) gnt_cnt[d]++;
                        else bad[d] = 1'b1;
                    end
                end

                if (mem_en[d]) begin
                    if (!have) begin
                        check({"en_unexpected", sfx}, 1'b1, 1'b0);
                    end else begin
                        en_cnt[d]++;
                        if (mem_addr[d] !== e.addr || mem_rw[d] !== e.rw ||
                            (e.chk_wdata && mem_wdata[d] !== e.wdata)) bad[d] = 1'b1;
                    end
                end

                if (fetch_done[d] || ls_done[d]) begin
                    if (!have) begin
                        check({"done_unexpected", sfx}, 1'b1, 1'b0);
                    end else begin
                        check({"done_owner", sfx}, {fetch_done[d], ls_done[d]},
                              (e.owner == OWNER_LS) ? 2'b01 : 2'b10);
                        check({"timeout_err", sfx}, timeout_err[d], e.tmo);
                        check({"en_cycles", sfx}, en_cnt[d], e.en_cycles);
                        check({"gnt_cycles", sfx}, gnt_cnt[d], e.en_cycles + 2);
                        check({"bus_values", sfx}, bad[d], 1'b0);
                        if (d == 0) void'(sb0.pop_front());
                        else        void'(sb1.pop_front());
                    end
                    en_cnt[d]  = 0;
                    gnt_cnt[d] = 0;
                    bad[d]     = 1'b0;
                end else if (timeout_err[d]) begin
                    check({"tmo_without_done", sfx}, 1'b1, 1'b0);
                end
            end
        end
    end

    // -------------------------------------------------------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_en(output bit ok);
        int i;
        i = 0;
        while (!mem_en[0] && i < 20) begin
            tick();
            i++;
        end
        ok = mem_en[0];
        if (!ok) check("wait_mem_en_budget", 1'b1, 1'b0);
    endtask

    task automatic wait_done(output bit ok);
        int i;
        i = 0;
        while (!(fetch_done[0] || ls_done[0]) && i < 40) begin
            tick();
            i++;
        end
        ok = fetch_done[0] || ls_done[0];
        if (!ok) check("wait_done_budget", 1'b1, 1'b0);
    endtask

    // mfc_delay: ACCESS cycles before MFC is raised (negative = never).
    task automatic do_access(input owner_e o, input logic [AW-1:0] a, input logic rw,
                             input logic [DW-1:0] wd, input int mfc_delay,
                             input bit mfc_early, input bit swap);
        exp_t e;
        bit   ok;
        int   en;
        bit   tmo;
        tmo = (mfc_delay < 0);
        en  = tmo ? TMO : mfc_delay + 1;
        e   = mk(o, a, rw, wd, tmo, en);
        sb0.push_back(e);
        sb1.push_back(e);
        if (o == OWNER_LS) begin
            ls_req = 1'b1; ls_addr = a; ls_rw = rw; ls_wdata = wd;
        end else begin
            fetch_req = 1'b1; fetch_addr = a;
        end
        if (mfc_early) MFC = 1'b1;
        wait_en(ok);
        MFC = 1'b0;
        if (swap) begin
            ls_wdata   = 16'h1234;
            ls_addr    = ~a;
            fetch_addr = ~a;
        end
        if (ok && mfc_delay >= 0) begin
            repeat (mfc_delay) tick();
            MFC = 1'b1;
            tick();
            MFC = 1'b0;
        end
        wait_done(ok);
        ls_req    = 1'b0;
        fetch_req = 1'b0;
    endtask

    task automatic check_idle_outs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_ctl"}, {fetch_gnt[d], ls_gnt[d], fetch_done[d], ls_done[d],
                                  mem_en[d], busy[d], timeout_err[d], mem_rw[d]}, 8'b0000_0001);
            check({tag, "_addr"}, mem_addr[d], '0);
            check({tag, "_wdata"}, mem_wdata[d], '0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired, expected completion");
        $fatal(1, "time limit");
    end

    initial begin
        bit ok;
        exp_t e;

        // Reset state
        reset = 1'b0;
        tick();
        tick();
        check_idle_outs("reset");
        reset = 1'b1;

        // MFC while idle is ignored
        MFC = 1'b1;
        repeat (3) begin
            tick();
            check("idle_mfc", {busy, mem_en}, 4'b0000);
        end
        MFC = 1'b0;
        tick();

        // Single read, MFC three cycles after mem_en rises
        do_access(OWNER_LS, 16'h0040, RW_RD, 16'h0000, 3, 1'b0, 1'b0);
        // Write; data/address inputs change during ACCESS
        do_access(OWNER_LS, 16'h0080, RW_WR, 16'hBEEF, 2, 1'b0, 1'b1);
        // Fetch read, MFC on first ACCESS cycle
        do_access(OWNER_FETCH, 16'h1234, RW_WR, 16'h0000, 0, 1'b0, 1'b0);
        // Watchdog abort
        do_access(OWNER_LS, 16'h00F0, RW_RD, 16'h0000, -1, 1'b0, 1'b0);
        // Next request proceeds normally
        do_access(OWNER_FETCH, 16'h2222, RW_RD, 16'h0000, 1, 1'b0, 1'b0);
        // MFC on the final watchdog cycle: no error
        do_access(OWNER_LS, 16'h0300, RW_WR, 16'hCAFE, TMO - 1, 1'b0, 1'b0);
        // MFC held through IDLE and GRANT is ignored
        do_access(OWNER_LS, 16'h0404, RW_RD, 16'h0000, 2, 1'b1, 1'b0);

        // Reset in the middle of an ACCESS: no done afterwards
        e = mk(OWNER_LS, 16'h0777, RW_RD, 16'h0000, 1'b0, 4);
        sb0.push_back(e);
        sb1.push_back(e);
        ls_req = 1'b1; ls_addr = 16'h0777; ls_rw = RW_RD;
        wait_en(ok);
        tick();
        tick();
        reset  = 1'b0;
        ls_req = 1'b0;
        tick();
        reset = 1'b1;
        check_idle_outs("reset_mid");
        repeat (3) tick();

        // Contention with both requests held: LS first for both modes
        fetch_addr = 16'h0F00;
        ls_addr    = 16'h0A00;
        ls_rw      = RW_WR;
        ls_wdata   = 16'h5A5A;
        for (int k = 0; k < 4; k++) begin
            sb0.push_back(mk(OWNER_LS, 16'h0A00, RW_WR, 16'h5A5A, 1'b0, 2));
            if (k % 2 == 0) sb1.push_back(mk(OWNER_LS, 16'h0A00, RW_WR, 16'h5A5A, 1'b0, 2));
            else            sb1.push_back(mk(OWNER_FETCH, 16'h0F00, RW_RD, 16'h5A5A, 1'b0, 2));
        end
        fetch_req = 1'b1;
        ls_req    = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_en(ok);
            tick();
            MFC = 1'b1;
            tick();
            MFC = 1'b0;
            wait_done(ok);
        end
        fetch_req = 1'b0;
        ls_req    = 1'b0;

        repeat (4) tick();
        check("sb_drained[0]", sb0.size(), 0);
        check("sb_drained[1]", sb1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single memory port (MAR/MDR, Enable, RW, MFC handshake) between the instruction-fetch requester and the Load_Store requester.
- Arbitrates between the two requesters and registers the winner's address, write data and direction.
- Sequences the memory access: drives enable, waits for MFC, then returns a one-cycle done pulse to the winner.
- A watchdog aborts any access whose MFC never arrives and flags a timeout.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, write-data width
- TIMEOUT_CYCLES, 15, max cycles in ACCESS without MFC (1..2^CNT_W-1)
- CNT_W, 4, watchdog counter width
- RR_MODE, 0, 0 = fixed priority (Load_Store wins), 1 = round-robin

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-low reset
- fetch_req  in  1  fetch requests a read
- fetch_addr  in  ADDR_W  fetch address
- fetch_gnt  out  1  fetch owns bus
- fetch_done  out  1  one-cycle completion pulse to fetch
- ls_req  in  1  Load_Store requests access
- ls_rw  in  1  1 = read, 0 = write
- ls_addr  in  ADDR_W  Load_Store address
- ls_wdata  in  DATA_W  Load_Store write data
- ls_gnt  out  1  Load_Store owns bus
- ls_done  out  1  one-cycle completion pulse to Load_Store
- mem_en  out  1  memory Enable
- mem_rw  out  1  memory RW, 1 = read
- mem_addr  out  ADDR_W  registered address to MAR
- mem_wdata  out  DATA_W  registered write data to MDR
- MFC  in  1  memory function complete
- busy  out  1  state != IDLE
- timeout_err  out  1  one-cycle pulse with done on watchdog abort

Behaviour:
- Reset: while reset==0 at a clk edge, the block enters the following values on that edge:
  - state = IDLE; owner = FETCH; last_owner = FETCH; watchdog counter = 0.
  - mem_addr and mem_wdata registers = 0.
  - All outputs 0, with mem_rw = 1.
- Reset mid-access: returns to IDLE on that edge. No done pulse is produced, and no timeout_err.
- FSM states are IDLE, GRANT, ACCESS, COMPLETE. Outputs are Moore, decoded from state registers.
- IDLE:
  - If no request, stay in IDLE.
  - If exactly one request, that requester wins.
  - If both request and RR_MODE=0, ls wins.
  - If both request and RR_MODE=1, the requester that is not last_owner wins.
  - On any win: latch owner, the winner's address, rw (fetch forces rw=1) and wdata (fetch: don't-care, hold). Next state is GRANT.
- GRANT (1 cycle):
  - Owner's gnt = 1; mem_addr and mem_wdata hold the latched values; mem_en = 0.
  - Next state is ACCESS; the counter clears.
- ACCESS:
  - gnt = 1, mem_en = 1, mem_rw = latched rw.
  - The counter increments each cycle.
  - If MFC = 1, go to COMPLETE.
  - Else if the counter reaches TIMEOUT_CYCLES-1, go to COMPLETE with the error flag set.
  - If MFC arrives on the same cycle as the timeout, MFC wins and no error is flagged.
- COMPLETE (1 cycle):
  - Owner's gnt = 1 and owner's done = 1.
  - timeout_err = error flag; mem_en = 0.
  - last_owner is set to owner. Next state is IDLE; the error flag clears.
- Latency:
  - From req seen in IDLE to mem_en: 2 cycles.
  - From MFC to done: 1 cycle.
  - Minimum request-to-request spacing: 4 cycles.
- MFC outside ACCESS is ignored.
- A requester holds req until its done. A req dropped after winning is ignored: the access completes and done still pulses.
- A req still high in the cycle after done is treated as a new request.
- Changes to input address/data after IDLE have no effect, because values are latched at the win.
- Only one gnt may be high at a time. gnt is 0 in IDLE.

Decomposition:
- Shared package (mem_arb_pkg):
  - state encoding, 2 bits: IDLE=0, GRANT=1, ACCESS=2, COMPLETE=3
  - owner IDs: FETCH=0, LS=1
  - RW constants: RD=1, WR=0
- One natural sub-module, mem_arb_pick (combinational):
  - inputs: fetch_req, ls_req, last_owner, RR_MODE
  - outputs: valid, winner
- The watchdog counter stays inline.

Test Plan:
- Single read: ls_req=1, ls_rw=1, ls_addr=0x0040; MFC=1 three cycles after mem_en rises.
  - Required: ls_gnt high 6 cycles; mem_addr=0x0040, mem_rw=1; ls_done pulses exactly once, the cycle after MFC.
- Write: ls_rw=0, ls_wdata=0xBEEF; change ls_wdata to 0x1234 during ACCESS.
  - Required: mem_wdata stays 0xBEEF; mem_rw=0 throughout ACCESS.
- Contention:
  - RR_MODE=0, both req held: ls served every time, fetch starves.
  - RR_MODE=1, both req held: grants alternate LS, FETCH, LS, FETCH; never two gnt high.
- Timeout: TIMEOUT_CYCLES=15, MFC held 0.
  - Required: mem_en high exactly 15 cycles; done and timeout_err pulse together; next request proceeds normally.
- Edge cases:
  - MFC on the final timeout cycle: done pulses, timeout_err=0.
  - MFC while in IDLE or GRANT: no effect.
- Reset mid-ACCESS: drive reset=0 for 1 cycle.
  - Required: next cycle IDLE, all outputs 0 with mem_rw=1, no done pulse.
  - First request afterwards, with both req high in RR mode: ls wins.
